// File: rtl/mem_responder.sv
// Byte-wide memory/IO responder: RAM with registered reads, a TX byte FIFO with
// back-pressure, a one-byte RX holding register and sticky halt/overflow flags.
module mem_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  mem_rw,
    input  logic [ADDR_WIDTH-1:0] mem_aout,
    input  logic [7:0]            mem_dout,
    output logic [7:0]            mem_din,
    output logic                  io_buffer_full,
    output logic [7:0]            io_tx_data,
    output logic                  io_tx_valid,
    input  logic                  io_tx_ready,
    input  logic [7:0]            io_rx_data,
    input  logic                  io_rx_valid,
    output logic                  io_rx_ready,
    output logic                  sim_end,
    output logic                  tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0] CNT_HIGH = (PW+1)'(TX_DEPTH - 1);

    logic [7:0]               ram [0:(1 << RAM_ADDR_BITS) - 1];
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic                     is_io;
    logic                     io_port0;
    logic                     io_port4;
    logic                     ram_we;
    logic                     tx_push;
    logic                     tx_pop;
    logic                     tx_accept;
    logic                     tx_full;
    logic                     rx_pop;
    logic                     halt_wr;
    logic [7:0]               rd_byte;

    logic [7:0]               tx_mem [0:TX_DEPTH-1];
    logic [PW-1:0]            tx_wptr;
    logic [PW-1:0]            tx_rptr;
    logic [PW:0]              tx_count;
    logic [PW:0]              tx_count_next;

    logic [7:0]               rx_hold;
    logic                     rx_full;

    assign ram_addr = mem_aout[RAM_ADDR_BITS-1:0];
    assign is_io    = (mem_aout[17:16] == 2'b11);
    assign io_port0 = is_io && (mem_aout[15:0] == 16'h0000);
    assign io_port4 = is_io && (mem_aout[15:0] == 16'h0004);

    assign ram_we   = rdy_in && mem_rw && !is_io;
    assign tx_push  = rdy_in && mem_rw && io_port0;
    assign halt_wr  = rdy_in && mem_rw && io_port4;
    assign rx_pop   = rdy_in && !mem_rw && io_port0 && rx_full;

    assign io_tx_valid = (tx_count != '0);
    assign io_tx_data  = tx_mem[tx_rptr];
    assign io_rx_ready = !rx_full;

    assign tx_pop    = io_tx_valid && io_tx_ready;
    assign tx_full   = (tx_count == CNT_FULL);
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign tx_accept = tx_push && (!tx_full || tx_pop);

    always_comb begin
        tx_count_next = tx_count;
        if (tx_accept && !tx_pop) begin
            tx_count_next = tx_count + (PW+1)'(1);
        end else if (!tx_accept && tx_pop) begin
            tx_count_next = tx_count - (PW+1)'(1);
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (!is_io) begin
            rd_byte = ram[ram_addr];
        end else if (io_port0) begin
            rd_byte = rx_full ? rx_hold : 8'h00;
        end else if (io_port4) begin
            rd_byte = {7'b0, (tx_count == '0)};
        end
    end

    // RAM array carries no reset so it can map onto memory macros.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
        if (tx_accept) begin
            tx_mem[tx_wptr] <= mem_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mem_din <= 8'h00;
        end else if (rdy_in && !mem_rw) begin
            mem_din <= rd_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            tx_wptr        <= '0;
            tx_rptr        <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            if (tx_accept) begin
                tx_wptr <= tx_wptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + PW'(1);
            end
            if (tx_push && !tx_accept) begin
                tx_overflow <= 1'b1;
            end
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= CNT_HIGH);
        end
    end

    // Capture only into an empty register, so a coinciding read sees the old state.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rx_hold <= 8'h00;
            rx_full <= 1'b0;
        end else if (io_rx_valid && !rx_full) begin
            rx_hold <= io_rx_data;
            rx_full <= 1'b1;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sim_end <= 1'b0;
        end else if (halt_wr) begin
            sim_end <= 1'b1;
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the byte address bus from the memory controller.
REQ-002 Parameter RAM_ADDR_BITS, default 17: byte-addressable RAM size, 2^RAM_ADDR_BITS bytes.
REQ-003 Parameter TX_DEPTH, default 8: output-byte FIFO depth; a power of two, at least 4.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst_in, input, 1: reset, asynchronous and active-low.
REQ-006 Port rdy_in, input, 1: global enable; low freezes all controller-side state.
REQ-007 Port mem_rw, input, 1: 1 = write, 0 = read, driven by the controller.
REQ-008 Port mem_aout, input, ADDR_WIDTH: byte address from the controller.
REQ-009 Port mem_dout, input, 8: write byte from the controller.
REQ-010 Port mem_din, output, 8: read byte returned to the controller.
REQ-011 Port io_buffer_full, output, 1: back-pressure flag to the controller.
REQ-012 Port io_tx_data, output, 8: head byte of the TX FIFO.
REQ-013 Port io_tx_valid, output, 1: TX FIFO non-empty.
REQ-014 Port io_tx_ready, input, 1: sink accepts the head byte this cycle.
REQ-015 Port io_rx_data, input, 8: incoming byte.
REQ-016 Port io_rx_valid, input, 1: incoming byte present.
REQ-017 Port io_rx_ready, output, 1: RX holding register empty.
REQ-018 Port sim_end, output, 1: sticky, set by a write to the halt port.
REQ-019 Port tx_overflow, output, 1: sticky, set when a TX push is dropped.

Function
REQ-020 Address decode: mem_aout[17:16]==2'b11 selects IO space; any other value selects RAM at mem_aout[RAM_ADDR_BITS-1:0].
REQ-021 RAM read: mem_din SHALL equal RAM[addr] one cycle after the address is presented (registered output, read latency 1).
REQ-022 RAM write: when rdy_in=1 and mem_rw=1, RAM[addr] <= mem_dout at the edge. A read of the same address in the next cycle returns the new byte.
REQ-023 IO write to 0x30000: pushes mem_dout into the TX FIFO. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and tx_overflow is set.
REQ-024 IO write to 0x30004: sets sim_end. Further writes keep it set.
REQ-025 IO read at 0x30000: returns rx_data if the RX register is full and clears it; returns 8'h00 otherwise. The result appears on mem_din with latency 1.
REQ-026 IO read at 0x30004: returns {7'b0, tx_fifo_empty} with latency 1. Reads of any other IO address return 8'h00.
REQ-027 A read of IO address 0x30000 is treated as a side-effecting pop exactly once per cycle the address is presented with mem_rw=0 and rdy_in=1.
REQ-028 TX drain: io_tx_valid = count!=0; io_tx_data = head byte; a pop occurs when io_tx_valid and io_tx_ready are both 1. Drain runs regardless of rdy_in.
REQ-029 Simultaneous push and pop: count is unchanged and the push is accepted, including when the FIFO is full.
REQ-030 Pointers wrap modulo TX_DEPTH; count ranges from 0 to TX_DEPTH.
REQ-031 io_buffer_full SHALL be registered and high whenever count >= TX_DEPTH-1. This leaves one entry of headroom for the controller's one-cycle-late reaction.
REQ-032 RX capture: when io_rx_valid=1 and the RX register is empty, capture io_rx_data.
REQ-033 If capture and an 0x30000 read coincide, the read returns the old byte and the new byte is held.
REQ-034 io_rx_ready = RX register empty.
REQ-035 rdy_in=0: no RAM write, no FIFO push, no RX pop, no sim_end change, mem_din holds its value. RX capture and TX drain continue.

Reset
REQ-036 While rst_in=0, asynchronously: mem_din=0, TX FIFO empty (io_tx_valid=0, io_buffer_full=0), RX register empty (io_rx_ready=1), sim_end=0, tx_overflow=0.
REQ-037 RAM contents are not reset.
REQ-038 Reset asserted mid-operation discards in-flight FIFO bytes; the first access after release behaves as from idle.

Verification
REQ-039 RAM round-trip: write 8'hA5 to 0x00010, then read 0x00010 -> mem_din=8'hA5 exactly one cycle after the read address.
REQ-040 Little-endian word: writes 0x13, 0x05, 0x10, 0x00 to 0x100..0x103; four consecutive reads -> mem_din sequence 0x13, 0x05, 0x10, 0x00, each at latency 1.
REQ-041 TX back-pressure with TX_DEPTH=8, io_tx_ready=0: push 7 bytes -> io_buffer_full=1 the cycle after the 7th push. 8th push accepted; 9th dropped with tx_overflow=1.
REQ-042 TX drain after REQ-041: raise io_tx_ready -> 8 bytes emerge in push order, then io_tx_valid=0 and io_buffer_full=0.
REQ-043 RX path: io_rx_valid with 8'h41 -> io_rx_ready=0. Read 0x30000 -> mem_din=8'h41, io_rx_ready=1. A second read -> 8'h00.
REQ-044 Halt and freeze: with rdy_in=0, write 0x30004 -> sim_end stays 0. With rdy_in=1, write 0x30004 -> sim_end=1. Pulse rst_in low mid-TX-drain -> all outputs at their REQ-036 values immediately.
